// File: rtl/ab_pattern_gen.sv
// rtl/ab_pattern_gen.sv - two-bit AB stimulus pattern generator with dwell and loop control
// Optional q/err/err_cnt result checker is enabled by defining AB_GEN_CHECK_EN.
module ab_pattern_gen #(
  parameter int DWELL_W = 4,
  parameter int LOOP_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DWELL_W-1:0] first_dwell,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [LOOP_W-1:0]  loops,
`ifdef AB_GEN_CHECK_EN
  input  logic               q,
  output logic               err,
  output logic [7:0]         err_cnt,
`endif
  output logic               a,
  output logic               b,
  output logic [1:0]         pat_idx,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [1:0]         pat_q, pat_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [LOOP_W-1:0]  loops_q, loops_d;
  logic [LOOP_W-1:0]  lcnt_q, lcnt_d;
  logic               a_q, a_d;
  logic               b_q, b_d;
  logic               accept;
  logic [DWELL_W-1:0] first_m1;
  logic [DWELL_W-1:0] dwell_m1;

  // Dwell counters hold "cycles remaining minus one", so a dwell of 0 behaves as 1.
  assign first_m1 = (first_dwell == '0) ? '0 : first_dwell - DWELL_W'(1);
  assign dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign accept   = (state_q == S_IDLE) && start && !abort;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    dcnt_d  = dcnt_q;
    dwell_d = dwell_q;
    loops_d = loops_q;
    lcnt_d  = lcnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
          pat_d   = 2'd0;
          dcnt_d  = first_m1;
          dwell_d = dwell_m1;
          loops_d = loops;
          lcnt_d  = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          pat_d   = 2'd0;
          dcnt_d  = '0;
          lcnt_d  = '0;
        end else if (dcnt_q != '0) begin
          dcnt_d = dcnt_q - DWELL_W'(1);
        end else if ((pat_q == 2'd3) && (loops_q != '0) &&
                     (lcnt_q == loops_q - LOOP_W'(1))) begin
          state_d = S_DONE;
          pat_d   = 2'd0;
          dcnt_d  = '0;
          lcnt_d  = '0;
        end else begin
          pat_d  = pat_q + 2'd1;
          dcnt_d = dwell_q;
          // With loops == 0 the loop count is irrelevant, so leave it parked.
          if ((pat_q == 2'd3) && (loops_q != '0)) begin
            lcnt_d = lcnt_q + LOOP_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        pat_d   = 2'd0;
        dcnt_d  = '0;
        lcnt_d  = '0;
      end
    endcase
    a_d = (state_d == S_RUN) & pat_d[1];
    b_d = (state_d == S_RUN) & pat_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pat_q   <= 2'd0;
      dcnt_q  <= '0;
      dwell_q <= '0;
      loops_q <= '0;
      lcnt_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      dcnt_q  <= dcnt_d;
      dwell_q <= dwell_d;
      loops_q <= loops_d;
      lcnt_q  <= lcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign pat_idx = pat_q;
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);

`ifdef AB_GEN_CHECK_EN
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  // q is compared against the bits currently on a/b, i.e. the downstream AND output.
  always_comb begin
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      err_d     = 1'b0;
      err_cnt_d = 8'd0;
    end else if ((state_q == S_RUN) && (q != (a_q & b_q))) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule
